// File: rtl/cp_insert.sv
// Cyclic-prefix inserter: ping-pong buffers one N-sample symbol per bank and
// replays its last cp samples ahead of the full symbol on a Wishbone-style output.
module cp_insert #(
   parameter int DW     = 32,
   parameter int NLOG2  = 6,
   parameter int CP_MAX = 32
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic [DW-1:0]    DAT_I,
   input  logic             CYC_I,
   input  logic             STB_I,
   input  logic             WE_I,
   output logic             ACK_O,
   input  logic [NLOG2:0]   CP_LEN_I,
   output logic [DW-1:0]    DAT_O,
   output logic             CYC_O,
   output logic             STB_O,
   output logic             WE_O,
   input  logic             ACK_I,
   output logic [15:0]      SYM_CNT_O
);

   localparam int N = 1 << NLOG2;
   localparam logic [NLOG2:0]   N_W      = (NLOG2+1)'(N);
   localparam logic [NLOG2:0]   CP_MAX_W = (NLOG2+1)'(CP_MAX);
   localparam logic [NLOG2-1:0] LAST     = '1;

   typedef enum logic [1:0] {IDLE, PREFIX, BODY} state_t;

   logic [DW-1:0]    mem [2][N];
   logic [1:0]       full, full_nxt;
   logic             wr_bank, rd_bank, cyc_d;
   logic [NLOG2-1:0] wr_idx, rd_idx, wr_at, emit_idx, pre_start;
   logic [NLOG2:0]   cp, pre_diff;
   logic             wr_last, slot_free, emit, emit_body, rd_done;
   state_t           state;

   // Write side: a fresh CYC_I restarts the symbol, so the accepted word lands at 0
   assign ACK_O   = CYC_I & STB_I & WE_I & ~full[wr_bank];
   assign wr_at   = (CYC_I & ~cyc_d) ? '0 : wr_idx;
   assign wr_last = ACK_O & (wr_at == LAST);

   always_ff @(posedge CLK_I)
      if (ACK_O) mem[wr_bank][wr_at] <= DAT_I;

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         cyc_d   <= 1'b0;
         wr_idx  <= '0;
         wr_bank <= 1'b0;
      end else begin
         cyc_d <= CYC_I;
         if (wr_last) begin
            wr_idx  <= '0;
            wr_bank <= ~wr_bank;
         end else if (ACK_O) begin
            wr_idx <= wr_at + 1'b1;
         end else begin
            wr_idx <= wr_at;
         end
      end
   end

   // Read side: the IDLE emission samples CP_LEN_I and picks the first word
   assign slot_free = ~STB_O | ACK_I;
   assign cp        = (CP_LEN_I > CP_MAX_W) ? CP_MAX_W : CP_LEN_I;
   assign pre_diff  = N_W - cp;
   assign pre_start = pre_diff[NLOG2-1:0];
   assign emit      = slot_free & ((state != IDLE) | full[rd_bank]);
   assign emit_body = (state == BODY) | ((state == IDLE) & (cp == '0));
   assign emit_idx  = (state != IDLE) ? rd_idx : (cp == '0) ? '0 : pre_start;
   assign rd_done   = emit & emit_body & (emit_idx == LAST);
   assign WE_O      = STB_O;

   // Set and clear always target opposite banks, so both apply on the same edge
   always_comb begin
      full_nxt = full;
      if (rd_done) full_nxt[rd_bank] = 1'b0;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) full <= '0;
      else        full <= full_nxt;
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         DAT_O     <= '0;
         STB_O     <= 1'b0;
         CYC_O     <= 1'b0;
         SYM_CNT_O <= '0;
         rd_idx    <= '0;
         rd_bank   <= 1'b0;
         state     <= IDLE;
      end else begin
         if (state == IDLE && !STB_O && full == 2'b00 && !CYC_I)
            CYC_O <= 1'b0;
         if (slot_free)
            STB_O <= emit;
         if (emit) begin
            DAT_O  <= mem[rd_bank][emit_idx];
            CYC_O  <= 1'b1;
            rd_idx <= emit_idx + 1'b1;
            if (emit_body) begin
               if (emit_idx == LAST) begin
                  rd_bank   <= ~rd_bank;
                  SYM_CNT_O <= SYM_CNT_O + 16'd1;
                  state     <= IDLE;
               end else begin
                  state <= BODY;
               end
            end else begin
               state <= (emit_idx == LAST) ? BODY : PREFIX;
            end
         end
      end
   end

endmodule

// File: doc/cp_insert.md
CP_INSERT -- requirements
Module: cp_insert

Interface
REQ-001 Parameter DW, 32, sample width (packed I/Q) on DAT_I/DAT_O.
REQ-002 Parameter NLOG2, 6, log2 of symbol length N (N = 2^NLOG2).
REQ-003 Parameter CP_MAX, 32, maximum cyclic-prefix length; SHALL satisfy 0 < CP_MAX <= N.
REQ-004 CLK_I  in  1  single clock; all logic on rising edge.
REQ-005 RST_I  in  1  reset, asynchronous, active-low.
REQ-006 DAT_I  in  DW  input sample (time-domain IFFT output, natural order).
REQ-007 CYC_I, STB_I, WE_I  in  1 each  input bus cycle, strobe, write.
REQ-008 ACK_O  out  1  input sample accepted this cycle.
REQ-009 CP_LEN_I  in  NLOG2+1  requested prefix length, sampled at symbol start.
REQ-010 DAT_O  out  DW  output sample, registered.
REQ-011 CYC_O, STB_O, WE_O  out  1 each  output cycle, strobe, write; WE_O = STB_O.
REQ-012 ACK_I  in  1  downstream accepts DAT_O.
REQ-013 SYM_CNT_O  out  16  count of completed output symbols, wraps at 65535 -> 0.

Function
REQ-014 Buffer: two banks of N x DW words (ping-pong), each with a full flag.
REQ-015 ACK_O SHALL = CYC_I & STB_I & WE_I & ~full[wr_bank], combinational.
REQ-016 Each ACK_O cycle writes DAT_I to wr_bank[wr_idx], wr_idx++; on wr_idx = N-1 set full[wr_bank], toggle wr_bank, wr_idx -> 0.
REQ-017 Rising edge of CYC_I (CYC_I=1, previous 0) SHALL reset wr_idx to 0, discarding any partial symbol; full banks are kept.
REQ-018 Output slot free when ~STB_O | ACK_I; DAT_O/STB_O change only on a free slot, else hold (no loss, no duplication).
REQ-019 FSM states IDLE, PREFIX, BODY.
REQ-020 IDLE, full[rd_bank] & slot free: cp = min(CP_LEN_I, CP_MAX); cp>0 -> emit word N-cp, go PREFIX; cp=0 -> emit word 0, go BODY.
REQ-021 PREFIX: emit indices N-cp .. N-1 in order, then BODY at index 0.
REQ-022 BODY: emit indices 0 .. N-1; emitting index N-1 clears full[rd_bank], toggles rd_bank, SYM_CNT_O++.
REQ-023 On emitting BODY index N-1, if other bank full: start next symbol on next free slot with no bubble (CP_LEN_I resampled); else IDLE.
REQ-024 Each emission: DAT_O <= mem[rd_bank][idx], STB_O <= 1; free slot with nothing to emit -> STB_O <= 0.
REQ-025 Latency: Nth sample accepted at edge t, ACK_I=1 -> first prefix word valid (STB_O=1) after edge t+1.
REQ-026 Same-edge set of full[wr_bank] and clear of full[rd_bank] on opposite banks SHALL both take effect.
REQ-027 Both banks full -> ACK_O = 0 until BODY index N-1 is emitted.
REQ-028 CYC_O set on first emission; cleared when FSM IDLE, STB_O=0, both banks empty and CYC_I=0.
REQ-029 Output length per symbol SHALL be exactly N+cp words.

Reset
REQ-030 RST_I=0 SHALL asynchronously clear DAT_O, STB_O, CYC_O, SYM_CNT_O, wr_idx, wr_bank, rd_bank, both full flags; FSM -> IDLE.
REQ-031 Reset mid-symbol discards all buffered data; bank memory contents need not be cleared.
REQ-032 After release, first ACK_O no earlier than first edge with RST_I=1.

Verification (N=64, CP_MAX=32)
REQ-033 One symbol DAT_I=k (k=0..63), CP_LEN_I=16, ACK_I=1 -> 80 contiguous strobes 48..63,0..63; SYM_CNT_O=1.
REQ-034 Two back-to-back symbols, ACK_I=1 -> 160 contiguous STB_O cycles, no gap; SYM_CNT_O=2.
REQ-035 ACK_I low 5 cycles during prefix word 50 -> DAT_O held at 50; sequence intact; ACK_O drops once third symbol arrives with both banks full.
REQ-036 CP_LEN_I=0 -> 64 words 0..63; CP_LEN_I=40 -> clamped, 96 words starting at 32.
REQ-037 CYC_I dropped after 20 samples, re-raised, 64 fresh samples -> only fresh symbol emitted.
REQ-038 RST_I pulsed low mid-body -> STB_O, CYC_O, SYM_CNT_O = 0 immediately; next symbol emitted correctly.
